corr_accum_bank: RTL and testbench
==================================

// Module: corr_accum_bank
// PURPOSE
//  Parametrised multi-tap correlator bank for one GPS tracking channel: generalises fixed early/prompt/late to NUM_TAPS.
//  Each tap accumulates code-wiped baseband I/Q samples over int_len code epochs, then dumps all taps at once via valid/ready.
//  Feeds DLL discriminator (outer taps) and Costas loop (centre tap); sits between carrier wipe-off and loop filters.
// PARAMETERS
//  NUM_TAPS  3   number of code-phase taps (tap 0 = earliest, NUM_TAPS/2 = prompt)
//  SAMPLE_W  4   signed width of sample_i/sample_q
//  ACC_W     24  signed accumulator width per tap per rail; saturating
//  CNT_W     5   width of int_len / epoch counter (max integration 2**CNT_W-1 ms)
// PORTS
//  clk          in   1                    rising-edge clock
//  rst_n        in   1                    synchronous, active-low reset
//  enable       in   1                    1 = run; 0 = clear and go IDLE
//  int_len      in   CNT_W                epochs per dump; 0 treated as 1; sampled at each period start
//  sample_valid in   1                    sample_i/q qualify this cycle
//  sample_i     in   SAMPLE_W             signed in-phase sample
//  sample_q     in   SAMPLE_W             signed quadrature sample
//  code_chips   in   NUM_TAPS             per-tap C/A chip; 0 -> +sample, 1 -> -sample
//  epoch        in   1                    code-period start; marks current sample as first of new epoch
//  dump_valid   out  1                    dump_i/dump_q hold a completed integration
//  dump_ready   in   1                    consumer accepts when dump_valid&dump_ready
//  dump_i       out  NUM_TAPS*ACC_W       per-tap I sums, tap k at [k*ACC_W +: ACC_W]
//  dump_q       out  NUM_TAPS*ACC_W       per-tap Q sums, same packing
//  overrun      out  1                    sticky: a dump was overwritten before acceptance
//  sat          out  1                    sticky: any accumulator saturated since last accepted dump
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, accumulators 0, epoch counter 0, state IDLE.
//  States: IDLE -> (enable) WAIT_EPOCH -> (epoch&sample_valid) ACCUM; enable=0 in any state -> IDLE next cycle.
//  WAIT_EPOCH discards samples; aligns integration to a code boundary. First accumulated sample is the epoch sample.
//  ACCUM: on sample_valid, acc_k += code_chips[k] ? -sample : +sample (sign-extend to ACC_W), both rails.
//  Epoch counter increments on each epoch&sample_valid in ACCUM; when it reaches latched int_len, period closes:
//   accumulators (excluding the closing sample) copied to dump regs, dump_valid=1 next cycle;
//   same cycle, accumulators load the closing sample's product (no sample lost), counter = 1, int_len re-latched.
//  epoch without sample_valid ignored. Latency: dump_valid rises 1 cycle after the closing epoch edge.
//  Handshake: dump regs stable while dump_valid&!dump_ready; dump_valid falls cycle after acceptance.
//   New period close while dump_valid&!dump_ready: dump regs overwritten, overrun=1, dump_valid stays 1.
//   Close coincident with acceptance: new data loaded, dump_valid stays 1, no overrun.
//  Saturation: sum clamps to +(2**(ACC_W-1)-1) / -(2**(ACC_W-1)); sets sat. sat cleared on accept, overrun only by reset.
//  enable=0 mid-period: accumulators and counter cleared, partial period never dumped; pending dump stays valid.
// CONFIGURATION
//  POWER_OUT_EN defined: extra output dump_pwr [NUM_TAPS*(2*ACC_W+1)], per-tap I*I+Q*Q unsigned;
//   computed in one pipeline stage, so dump_valid rises 2 cycles after closing epoch; dump_pwr aligned with dump_i/q.
//  Not defined: no dump_pwr port, no multipliers, latency 1 cycle as above.
// STRUCTURE
//  Package gps_track_pkg: corr_state_t enum {IDLE, WAIT_EPOCH, ACCUM}; function sat_add(a,b) parametrised on ACC_W;
//   chip polarity constant CHIP_ZERO_POSITIVE=1.
//  Sub-module corr_tap: one I/Q accumulator pair with wipe, saturating add, load/clear; generate NUM_TAPS copies.
//  Top holds FSM, epoch counter, int_len latch, dump regs, handshake and sticky flags.
// TESTING (NUM_TAPS=3, SAMPLE_W=4, ACC_W=16, CNT_W=5 unless noted)
//  1 Reset: drive rst_n=0 with active inputs -> all outputs 0; after release, WAIT_EPOCH ignores samples before epoch.
//  2 int_len=1, I=3,Q=-2, chips=3'b010, epoch on sample 1 and 11 of continuous valid -> dump_i={30,-30,30}, dump_q={-20,20,-20}.
//  3 int_len=2, same stimulus over 3 epochs of 10 -> single dump after 2nd boundary, dump_i tap0=60; no dump at 1st.
//  4 dump_ready=0 across two closes -> overrun=1, second period's values shown; ready=1 -> dump_valid falls next cycle.
//  5 ACC_W=8, I=7, chips=0, 20 samples in period -> dump_i tap0=127, sat=1; cleared after acceptance.
//  6 enable=0 at sample 5 then re-enable -> no partial dump; POWER_OUT_EN: I=30,Q=-20 -> dump_pwr tap=1300, latency 2.

Source files
------------

// File: rtl/gps_track_pkg.sv
// gps_track_pkg: shared types, constants and saturating adder for the GPS tracking correlators
package gps_track_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_EPOCH, ACCUM} corr_state_t;
  localparam bit CHIP_ZERO_POSITIVE = 1'b1;
  localparam int SAT_MAX_W = 64;
  // Callers sign-extend their operands to SAT_MAX_W and pass their real width w; the result is
  // clamped to the signed range of w bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int w
  );
    logic signed [SAT_MAX_W:0] s, hi, lo;
    s = (SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b);
    hi = ((SAT_MAX_W+1)'(1) << (w - 1)) - (SAT_MAX_W+1)'(1);
    lo = -hi - (SAT_MAX_W+1)'(1);
    return s > hi ? hi[SAT_MAX_W-1:0] : s < lo ? lo[SAT_MAX_W-1:0] : s[SAT_MAX_W-1:0];
  endfunction
endpackage

// File: rtl/corr_tap.sv
// corr_tap: one code-wiped, saturating I/Q accumulator pair
//  clk, rst_n (sync, active-low); clear/load/add controls (clear > load > add);
//  chip selects sample polarity; sample_i/q signed inputs; acc_i/q running sums;
//  sat pulses when this cycle's add clamps either rail.
module corr_tap import gps_track_pkg::*; #(
  parameter int SAMPLE_W = 4,
  parameter int ACC_W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       add,
  input  logic                       chip,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  output logic signed [ACC_W-1:0]    acc_i,
  output logic signed [ACC_W-1:0]    acc_q,
  output logic                       sat
);
  logic neg;
  logic signed [ACC_W-1:0] p_i, p_q;
  logic signed [SAT_MAX_W-1:0] w_i, w_q, f_i, f_q;
  always_comb begin
    neg = CHIP_ZERO_POSITIVE ? chip : !chip;
    p_i = neg ? -ACC_W'(sample_i) : ACC_W'(sample_i);
    p_q = neg ? -ACC_W'(sample_q) : ACC_W'(sample_q);
    f_i = SAT_MAX_W'(acc_i) + SAT_MAX_W'(p_i);
    f_q = SAT_MAX_W'(acc_q) + SAT_MAX_W'(p_q);
    w_i = sat_add(SAT_MAX_W'(acc_i), SAT_MAX_W'(p_i), ACC_W);
    w_q = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(p_q), ACC_W);
    sat = add && (w_i != f_i || w_q != f_q);
  end
  always_ff @(posedge clk)
    if (!rst_n || clear) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (load) begin
      acc_i <= p_i;
      acc_q <= p_q;
    end else if (add) begin
      acc_i <= w_i[ACC_W-1:0];
      acc_q <= w_q[ACC_W-1:0];
    end
endmodule

// File: rtl/corr_accum_bank.sv
// corr_accum_bank: NUM_TAPS-tap I/Q correlator bank, integrates int_len code epochs and dumps via valid/ready
//  Inputs : clk, rst_n (sync, active-low), enable, int_len, sample_valid, sample_i/q,
//           code_chips (per tap, 1 = negate), epoch, dump_ready
//  Outputs: dump_valid, dump_i/dump_q (tap k at [k*ACC_W +: ACC_W]), overrun (sticky), sat (sticky)
//  POWER_OUT_EN: adds dump_pwr (per-tap I*I+Q*Q) through one extra pipeline stage.
module corr_accum_bank import gps_track_pkg::*; #(
  parameter int NUM_TAPS = 3,
  parameter int SAMPLE_W = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [CNT_W-1:0]                 int_len,
  input  logic                             sample_valid,
  input  logic signed [SAMPLE_W-1:0]       sample_i,
  input  logic signed [SAMPLE_W-1:0]       sample_q,
  input  logic [NUM_TAPS-1:0]              code_chips,
  input  logic                             epoch,
  output logic                             dump_valid,
  input  logic                             dump_ready,
  output logic [NUM_TAPS*ACC_W-1:0]        dump_i,
  output logic [NUM_TAPS*ACC_W-1:0]        dump_q,
`ifdef POWER_OUT_EN
  output logic [NUM_TAPS*(2*ACC_W+1)-1:0]  dump_pwr,
`endif
  output logic                             overrun,
  output logic                             sat
);
  corr_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, len;
  logic hit, start, close, add, accept, sat_any, load_dump;
  logic [NUM_TAPS-1:0] tap_sat;
  logic [NUM_TAPS*ACC_W-1:0] acc_i, acc_q, src_i, src_q;
  // cnt counts epochs begun in the current period, so a period closes on the epoch after cnt reaches len
  always_comb begin
    hit = enable && epoch && sample_valid;
    start = state == WAIT_EPOCH && hit;
    close = state == ACCUM && hit && cnt == len;
    add = state == ACCUM && enable && sample_valid && !close;
    accept = dump_valid && dump_ready;
    sat_any = |tap_sat;
    state_nx = !enable ? IDLE : state == IDLE ? WAIT_EPOCH : start ? ACCUM : state;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (!rst_n || !enable) begin
      cnt <= '0;
      len <= '0;
    end else if (start || close) begin
      cnt <= CNT_W'(1);
      len <= int_len == '0 ? CNT_W'(1) : int_len;
    end else if (state == ACCUM && hit) begin
      cnt <= cnt + 1'b1;
    end
  // Closing sample is loaded rather than added, so it opens the next period
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    corr_tap #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_tap (
      .clk(clk),
      .rst_n(rst_n),
      .clear(!enable),
      .load(start || close),
      .add(add),
      .chip(code_chips[k]),
      .sample_i(sample_i),
      .sample_q(sample_q),
      .acc_i(acc_i[k*ACC_W +: ACC_W]),
      .acc_q(acc_q[k*ACC_W +: ACC_W]),
      .sat(tap_sat[k])
    );
  end
`ifdef POWER_OUT_EN
  logic stage_v;
  logic [NUM_TAPS*ACC_W-1:0] stage_i, stage_q;
  logic [NUM_TAPS*(2*ACC_W+1)-1:0] pwr;
  // Stage holds the closed sums while power is computed; it completes even if enable drops
  always_ff @(posedge clk) begin
    stage_v <= rst_n && close;
    stage_i <= !rst_n ? '0 : close ? acc_i : stage_i;
    stage_q <= !rst_n ? '0 : close ? acc_q : stage_q;
  end
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pwr
    logic signed [2*ACC_W-1:0] sq_i, sq_q;
    assign sq_i = $signed(stage_i[k*ACC_W +: ACC_W]) * $signed(stage_i[k*ACC_W +: ACC_W]);
    assign sq_q = $signed(stage_q[k*ACC_W +: ACC_W]) * $signed(stage_q[k*ACC_W +: ACC_W]);
    assign pwr[k*(2*ACC_W+1) +: 2*ACC_W+1] = {1'b0, sq_i} + {1'b0, sq_q};
  end
  always_comb begin
    load_dump = stage_v;
    src_i = stage_i;
    src_q = stage_q;
  end
  always_ff @(posedge clk) dump_pwr <= !rst_n ? '0 : load_dump ? pwr : dump_pwr;
`else
  always_comb begin
    load_dump = close;
    src_i = acc_i;
    src_q = acc_q;
  end
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      dump_valid <= 1'b0;
      dump_i <= '0;
      dump_q <= '0;
      overrun <= 1'b0;
      sat <= 1'b0;
    end else begin
      dump_valid <= load_dump || (dump_valid && !dump_ready);
      if (load_dump) begin
        dump_i <= src_i;
        dump_q <= src_q;
      end
      overrun <= overrun || (load_dump && dump_valid && !dump_ready);
      sat <= sat_any || (sat && !accept);
    end
endmodule

// File: tb/tb_corr_accum_bank.sv
// tb_corr_accum_bank: scoreboard bench for corr_accum_bank (16-bit main instance plus an 8-bit saturation instance)
module tb_corr_accum_bank;
  localparam int N = 3;
  localparam int SW = 4;
  localparam int AW = 16;
  localparam int CW = 5;
`ifdef POWER_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst_n = 0, enable = 0, sample_valid = 0, epoch = 0, dump_ready = 0;
  logic [CW-1:0] int_len = 1;
  logic signed [SW-1:0] sample_i = 0, sample_q = 0;
  logic [N-1:0] code_chips = 0;
  logic dump_valid, overrun, sat, dv8, ov8, sat8;
  logic [N*AW-1:0] dump_i, dump_q, ei, eq;
  logic [N*8-1:0] d8_i, d8_q;
`ifdef POWER_OUT_EN
  logic [N*(2*AW+1)-1:0] dump_pwr;
  logic [N*17-1:0] pwr8;
`endif
  logic [N*AW-1:0] exp_i[$], exp_q[$];
  int vec = 0, errs = 0;

  corr_accum_bank #(.NUM_TAPS(N), .SAMPLE_W(SW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .int_len(int_len), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .code_chips(code_chips), .epoch(epoch),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_i(dump_i), .dump_q(dump_q),
`ifdef POWER_OUT_EN
    .dump_pwr(dump_pwr),
`endif
    .overrun(overrun), .sat(sat));

  corr_accum_bank #(.NUM_TAPS(N), .SAMPLE_W(SW), .ACC_W(8), .CNT_W(CW)) u8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .int_len(int_len), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .code_chips(code_chips), .epoch(epoch),
    .dump_valid(dv8), .dump_ready(dump_ready), .dump_i(d8_i), .dump_q(d8_q),
`ifdef POWER_OUT_EN
    .dump_pwr(pwr8),
`endif
    .overrun(ov8), .sat(sat8));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [N*AW-1:0] pack(input int a, input int b, input int c);
    return {AW'(c), AW'(b), AW'(a)};
  endfunction

`ifdef POWER_OUT_EN
  function automatic logic [N*(2*AW+1)-1:0] pwr_of(input logic [N*AW-1:0] pi, input logic [N*AW-1:0] pq);
    logic [N*(2*AW+1)-1:0] r;
    longint a, b;
    r = '0;
    for (int k = 0; k < N; k++) begin
      a = longint'($signed(pi[k*AW +: AW]));
      b = longint'($signed(pq[k*AW +: AW]));
      r[k*(2*AW+1) +: 2*AW+1] = (2*AW+1)'(a * a + b * b);
    end
    return r;
  endfunction
`endif

  // One clock; the scoreboard is popped on the falling edge whenever a dump handshake is pending
  task automatic step();
    @(negedge clk);
    if (rst_n && dump_valid && dump_ready) begin
      vec++;
      if (exp_i.size() == 0) begin
        errs++;
        $display("FAIL dump_unexpected got i=%h q=%h", dump_i, dump_q);
      end else begin
        ei = exp_i.pop_front();
        eq = exp_q.pop_front();
        if (dump_i !== ei || dump_q !== eq) begin
          errs++;
          $display("FAIL dump_data got i=%h q=%h expected i=%h q=%h", dump_i, dump_q, ei, eq);
        end
`ifdef POWER_OUT_EN
        vec++;
        if (dump_pwr !== pwr_of(ei, eq)) begin
          errs++;
          $display("FAIL dump_pwr got %h expected %h", dump_pwr, pwr_of(ei, eq));
        end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int i, input int q, input logic [N-1:0] c, input logic ep);
    sample_valid = 1;
    sample_i = SW'(i);
    sample_q = SW'(q);
    code_chips = c;
    epoch = ep;
    step();
    epoch = 0;
  endtask

  task automatic restart();
    sample_valid = 0;
    enable = 0;
    repeat (3) step();
    enable = 1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    enable = 1;
    sample_valid = 1;
    epoch = 1;
    dump_ready = 1;
    sample_i = 7;
    code_chips = '1;
    repeat (3) step();
    vec++;
    if ({dump_valid, overrun, sat, dump_i, dump_q} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got v=%b o=%b s=%b i=%h q=%h expected all 0", dump_valid, overrun, sat, dump_i, dump_q);
    end
`ifdef POWER_OUT_EN
    vec++;
    if (dump_pwr !== '0) begin
      errs++;
      $display("FAIL reset_pwr got %h expected 0", dump_pwr);
    end
`endif
    rst_n = 1;
    epoch = 0;
    repeat (5) smp(5, 5, 3'b000, 0);
    vec++;
    if (dump_valid !== 1'b0) begin
      errs++;
      $display("FAIL wait_epoch_discard got dump_valid=%b expected 0", dump_valid);
    end
  endtask

  task automatic test_periods(input int len, input string name);
    int nd = 3 - len;
    int_len = CW'(len);
    dump_ready = 1;
    for (int d = 0; d < nd; d++) begin
      exp_i.push_back(pack(30 * len, -30 * len, 30 * len));
      exp_q.push_back(pack(-20 * len, 20 * len, -20 * len));
    end
    for (int e = 0; e < 3; e++)
      for (int s = 0; s < 10; s++) begin
        smp(3, -2, 3'b010, s == 0);
        if (s == LAT - 1) begin
          vec++;
          if (dump_valid !== (e >= len)) begin
            errs++;
            $display("FAIL %s_latency epoch %0d got dump_valid=%b expected %b", name, e, dump_valid, e >= len);
          end
        end
      end
    restart();
    vec++;
    if (exp_i.size() != 0) begin
      errs++;
      $display("FAIL %s_drain got %0d pending expected 0", name, exp_i.size());
    end
  endtask

  task automatic test_overrun();
    int_len = 1;
    dump_ready = 0;
    exp_i.push_back(pack(10, 10, 10));
    exp_q.push_back(pack(5, 5, 5));
    for (int s = 0; s < 5; s++) smp(1, 1, 3'b000, s == 0);
    for (int s = 0; s < 5; s++) smp(2, 1, 3'b000, s == 0);
    vec++;
    if (dump_valid !== 1'b1 || overrun !== 1'b0 || dump_i !== pack(5, 5, 5)) begin
      errs++;
      $display("FAIL overrun_first got v=%b o=%b i=%h expected v=1 o=0 i=%h", dump_valid, overrun, dump_i, pack(5, 5, 5));
    end
    smp(3, 3, 3'b000, 1);
    sample_valid = 0;
    enable = 0;
    repeat (LAT + 1) step();
    vec++;
    if (dump_valid !== 1'b1 || overrun !== 1'b1) begin
      errs++;
      $display("FAIL overrun_set got v=%b o=%b expected v=1 o=1", dump_valid, overrun);
    end
    enable = 1;
    dump_ready = 1;
    step();
    vec++;
    if (dump_valid !== 1'b0 || overrun !== 1'b1) begin
      errs++;
      $display("FAIL overrun_accept got v=%b o=%b expected v=0 o=1", dump_valid, overrun);
    end
    vec++;
    if (exp_i.size() != 0) begin
      errs++;
      $display("FAIL overrun_drain got %0d pending expected 0", exp_i.size());
    end
  endtask

  task automatic test_saturation();
    rst_n = 0;
    dump_ready = 0;
    repeat (2) step();
    rst_n = 1;
    enable = 1;
    int_len = 1;
    step();
    exp_i.push_back(pack(140, 140, 140));
    exp_q.push_back(pack(0, 0, 0));
    for (int s = 0; s < 20; s++) smp(7, 0, 3'b000, s == 0);
    smp(7, 0, 3'b000, 1);
    sample_valid = 0;
    enable = 0;
    repeat (LAT) step();
    vec++;
    if (dv8 !== 1'b1 || d8_i !== {8'd127, 8'd127, 8'd127} || d8_q !== '0) begin
      errs++;
      $display("FAIL sat_clamp got v=%b i=%h q=%h expected v=1 i=7f7f7f q=0", dv8, d8_i, d8_q);
    end
    vec++;
    if (sat8 !== 1'b1 || sat !== 1'b0) begin
      errs++;
      $display("FAIL sat_flag got sat8=%b sat16=%b expected 1 0", sat8, sat);
    end
    dump_ready = 1;
    step();
    vec++;
    if (sat8 !== 1'b0 || dv8 !== 1'b0) begin
      errs++;
      $display("FAIL sat_clear got sat8=%b v8=%b expected 0 0", sat8, dv8);
    end
  endtask

  task automatic test_disable();
    restart();
    int_len = 2;
    dump_ready = 1;
    for (int s = 0; s < 10; s++) smp(3, -2, 3'b010, s == 0);
    for (int s = 0; s < 4; s++) smp(3, -2, 3'b010, s == 0);
    enable = 0;
    smp(3, -2, 3'b010, 0);
    enable = 1;
    repeat (LAT + 2) smp(3, -2, 3'b010, 0);
    vec++;
    if (dump_valid !== 1'b0) begin
      errs++;
      $display("FAIL disable_partial got dump_valid=%b expected 0", dump_valid);
    end
    exp_i.push_back(pack(60, -60, 60));
    exp_q.push_back(pack(-40, 40, -40));
    for (int e = 0; e < 3; e++)
      for (int s = 0; s < 10; s++) begin
        smp(3, -2, 3'b010, s == 0);
        if (s == LAT - 1) begin
          vec++;
          if (dump_valid !== (e == 2)) begin
            errs++;
            $display("FAIL disable_resume epoch %0d got dump_valid=%b expected %b", e, dump_valid, e == 2);
          end
        end
      end
    restart();
    vec++;
    if (exp_i.size() != 0) begin
      errs++;
      $display("FAIL disable_drain got %0d pending expected 0", exp_i.size());
    end
  endtask

  initial begin
    test_reset();
    test_periods(1, "int_len1");
    test_periods(2, "int_len2");
    test_overrun();
    test_saturation();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
